// File: rtl/viterbi_decode_if.sv
// Symbol-in / decoded-bit-out bundle for viterbi_decode.
// err_cnt_sig exists only when VITERBI_ERRCNT_EN is defined.
interface viterbi_decode_if;
  logic        en_sig;
  logic [1:0]  encode_sig;
  logic        dec_sig;
  logic        dec_vld_sig;
`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_cnt_sig;

  modport master (output en_sig, encode_sig, input dec_sig, dec_vld_sig, err_cnt_sig);
  modport slave  (input en_sig, encode_sig, output dec_sig, dec_vld_sig, err_cnt_sig);
`else
  modport master (output en_sig, encode_sig, input dec_sig, dec_vld_sig);
  modport slave  (input en_sig, encode_sig, output dec_sig, dec_vld_sig);
`endif
endinterface

// File: rtl/viterbi_decode.sv
// Hard-decision 4-state Viterbi decoder (K=3, G0=111, G1=101) with register-exchange survivors.
// Optional channel-error estimate on err_cnt_sig when VITERBI_ERRCNT_EN is defined.
module viterbi_decode #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 4
) (
  input  logic            clk_sig,
  input  logic            rst_sig,
  viterbi_decode_if.slave bus
);
  localparam int            CNT_W  = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     pm_d   [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [TB_DEPTH-1:0] surv_d [4];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dec_q, dec_d;
  logic                vld_q, vld_d;

  logic [PM_W:0]       cand0    [4];
  logic [PM_W:0]       cand1    [4];
  logic                sel      [4];
  logic [PM_W:0]       acs_pm   [4];
  logic [PM_W:0]       diff_pm  [4];
  logic [PM_W-1:0]     norm_pm  [4];
  logic [TB_DEPTH-1:0] acs_surv [4];
  logic [PM_W:0]       min_pm;
  logic [1:0]          best;

  function automatic logic [PM_W:0] bm(input logic [1:0] rx, input logic [1:0] ex);
    logic [1:0] d;
    d = rx ^ ex;
    return {{PM_W{1'b0}}, d[1]} + {{PM_W{1'b0}}, d[0]};
  endfunction

  // Next state {b,x} is reached from {x,0} with symbol {b^x,b} or from {x,1} with its complement
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      cand0[ns]    = {1'b0, pm_q[{ns[0], 1'b0}]} + bm(bus.encode_sig, {ns[1] ^ ns[0], ns[1]});
      cand1[ns]    = {1'b0, pm_q[{ns[0], 1'b1}]} + bm(bus.encode_sig, ~{ns[1] ^ ns[0], ns[1]});
      sel[ns]      = cand1[ns] < cand0[ns];
      acs_pm[ns]   = sel[ns] ? cand1[ns] : cand0[ns];
      acs_surv[ns] = {surv_q[{ns[0], sel[ns]}][TB_DEPTH-2:0], ns[1]};
    end
    min_pm = acs_pm[0];
    best   = 2'd0;
    for (int ns = 1; ns < 4; ns++) begin
      if (acs_pm[ns] < min_pm) begin
        min_pm = acs_pm[ns];
        best   = 2'(ns);
      end
    end
    for (int ns = 0; ns < 4; ns++) begin
      diff_pm[ns] = acs_pm[ns] - min_pm;
      norm_pm[ns] = (diff_pm[ns] > PM_MAX) ? {PM_W{1'b1}} : diff_pm[ns][PM_W-1:0];
    end
  end

  // Idle edges hold all decode state; only the qualifier drops
  always_comb begin
    pm_d   = pm_q;
    surv_d = surv_q;
    cnt_d  = cnt_q;
    dec_d  = dec_q;
    vld_d  = 1'b0;
    if (bus.en_sig) begin
      pm_d   = norm_pm;
      surv_d = acs_surv;
      cnt_d  = (cnt_q == CNT_W'(TB_DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
      dec_d  = acs_surv[best][TB_DEPTH-1];
      vld_d  = (cnt_q >= CNT_W'(TB_DEPTH - 1));
    end
  end

  // Start in state 0: the other states carry a penalty so the encoder's known start wins
  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      pm_q[0] <= {PM_W{1'b0}};
      pm_q[1] <= PM_W'(4);
      pm_q[2] <= PM_W'(4);
      pm_q[3] <= PM_W'(4);
      for (int s = 0; s < 4; s++) surv_q[s] <= {TB_DEPTH{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      dec_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      pm_q   <= pm_d;
      surv_q <= surv_d;
      cnt_q  <= cnt_d;
      dec_q  <= dec_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.dec_sig     = dec_q;
  assign bus.dec_vld_sig = vld_q;

`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_q, err_d;
  logic [16:0] err_sum;

  // The normalisation amount is the metric growth of the best path, i.e. bit errors seen
  always_comb begin
    err_sum = {1'b0, err_q} + 17'(min_pm);
    err_d   = err_q;
    if (bus.en_sig) begin
      err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  // Error-count register
  always_ff @(posedge clk_sig) begin
    if (rst_sig) err_q <= 16'h0000;
    else         err_q <= err_d;
  end

  assign bus.err_cnt_sig = err_q;
`endif
endmodule

// File: tb/tb_viterbi_decode.sv
// Directed bench for viterbi_decode: reference K=3 encoder fed by a 4-bit m-sequence,
// decoded stream compared to the source delayed by TB_DEPTH-1 accepted symbols.
module tb_viterbi_decode;
  localparam int TBD = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] enc_s;
  logic [3:0] lfsr;
  logic       hist [0:1023];
  int         acc;
  logic       exp_dec;
  logic       exp_vld;

  viterbi_decode_if vif ();

  viterbi_decode #(.TB_DEPTH(TBD), .PM_W(4)) dut (
    .clk_sig (clk),
    .rst_sig (rst),
    .bus     (vif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (accepted=%0d)", tag, obs, exp, acc);
    end
  endtask

  task automatic src_bit(output logic b);
    b    = lfsr[3];
    lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  endtask

  // One clock: optionally accept a source bit (encoded, optionally with bit 1 flipped)
  task automatic step(input logic b, input logic en, input logic flip);
    logic [1:0] sym;
    if (en) begin
      sym    = {b ^ enc_s[1] ^ enc_s[0], b ^ enc_s[0]};
      sym[1] = sym[1] ^ flip;
      enc_s  = {b, enc_s[1]};
      hist[acc] = b;
      acc++;
    end else begin
      sym = 2'($urandom_range(0, 3));
    end
    vif.en_sig     = en;
    vif.encode_sig = sym;
    @(posedge clk);
    #1;
    if (en) begin
      if (acc >= TBD) begin
        exp_vld = 1'b1;
        exp_dec = hist[acc - TBD];
      end else begin
        exp_vld = 1'b0;
        exp_dec = 1'b0;
      end
    end else begin
      exp_vld = 1'b0;
    end
    check("dec_vld", 16'(vif.dec_vld_sig), 16'(exp_vld));
    check("dec", 16'(vif.dec_sig), 16'(exp_dec));
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst            = 1'b1;
      vif.en_sig     = 1'b1;
      vif.encode_sig = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      check("rst_vld", 16'(vif.dec_vld_sig), 16'h0000);
      check("rst_dec", 16'(vif.dec_sig), 16'h0000);
`ifdef VITERBI_ERRCNT_EN
      check("rst_err", vif.err_cnt_sig, 16'h0000);
`endif
    end
    rst     = 1'b0;
    acc     = 0;
    enc_s   = 2'b00;
    exp_dec = 1'b0;
    lfsr    = 4'b1001;
  endtask

  task automatic run_src(input int n, input int gap_pct, input logic flips);
    logic b;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 99) < gap_pct) step(1'b0, 1'b0, 1'b0);
      end
      src_bit(b);
      step(b, 1'b1, flips && (acc == 40 || acc == 80 || acc == 120));
    end
  endtask

  initial begin
    rst            = 1'b1;
    vif.en_sig     = 1'b0;
    vif.encode_sig = 2'b00;

    // Reset held two cycles, then error-free continuous stream
    do_reset(2);
    run_src(200, 0, 1'b0);
`ifdef VITERBI_ERRCNT_EN
    check("err_clean", vif.err_cnt_sig, 16'h0000);
`endif

    // Isolated channel errors on symbols 40, 80, 120
    do_reset(1);
    run_src(140, 0, 1'b1);
`ifdef VITERBI_ERRCNT_EN
    check("err_isolated", vif.err_cnt_sig, 16'h0003);
`endif

    // Gapped input: same source, random idle cycles
    do_reset(1);
    run_src(200, 30, 1'b0);

    // Mid-stream reset at symbol 50, then refill and decode relative to new input
    do_reset(1);
    run_src(50, 0, 1'b0);
    do_reset(1);
    run_src(40, 0, 1'b0);

    // All-zero symbols: metric of state 0 stays 0
    do_reset(1);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i % 10 == 9) check("pm0_zero", 16'(dut.pm_q[0]), 16'h0000);
    end
`ifdef VITERBI_ERRCNT_EN
    check("err_zero", vif.err_cnt_sig, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/viterbi_decode.md
# viterbi_decode

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code produced by `ConvEncode`. It sits directly downstream of the encoder (or of the channel/demapper that carries its symbols). It consumes one 2-bit code symbol per enabled clock and emits one decoded data bit per enabled clock once the survivor memory has filled. It uses a 4-state add-compare-select core with register-exchange survivor storage.

## Interface
- `TB_DEPTH`, 16, survivor length in symbols; decode latency in accepted symbols; legal range 8–32.
- `PM_W`, 4, path-metric width in bits; minimum 4.
- `clk_sig`  in  1  single clock; all logic on the rising edge.
- `rst_sig`  in  1  reset; synchronous, active-high.
- `en_sig`  in  1  symbol valid; `encode_sig` is accepted on every rising edge with `en_sig`=1.
- `encode_sig`  in  2  code symbol: bit 1 = G0 (111) output, bit 0 = G1 (101) output.
- `dec_sig`  out  1  decoded data bit, registered.
- `dec_vld_sig`  out  1  one-cycle qualifier for `dec_sig`, registered.
- `err_cnt_sig`  out  16  channel-error estimate; present only with `VITERBI_ERRCNT_EN`.

## Operation
- **Trellis**
  - State s = {b[n-1], b[n-2]}.
  - Input bit b gives next state {b, s[1]}.
  - Expected symbol = {b^s[1]^s[0], b^s[0]}.
- **Predecessors:** next state {b, x} has predecessors {x,0} (p0) and {x,1} (p1).
- **Branch metric:** Hamming distance between `encode_sig` and the expected symbol, range 0..2.
- **ACS per next state**
  - cand0 = PM[p0]+BM0 and cand1 = PM[p1]+BM1, computed at PM_W+1 bits.
  - Select the smaller candidate; on a tie, p0 wins.
- **Normalization**
  - Subtract the minimum of the four new metrics from all four before storing, so the stored minimum is always 0.
  - Stored metrics never exceed 2^PM_W−1.
- **Survivors:** surv[ns] <= {surv[sel_pred][TB_DEPTH-2:0], ns[1]}. Bit 0 holds the newest decision.
- **Best state**
  - The state with the smallest new metric; ties go to the lowest index.
  - `dec_sig` <= bit TB_DEPTH-1 of that state's new survivor.
- **Fill counter:** `cnt` counts accepted symbols and saturates at TB_DEPTH.
- **Output qualifier:** `dec_vld_sig` <= `en_sig` && (`cnt` >= TB_DEPTH-1).
- **Edges with `en_sig`=0**
  - Metrics, survivors, `cnt` and `dec_sig` hold.
  - `dec_vld_sig` goes to 0.
- **Stream framing:** no tail flush and no frame boundaries; the stream is continuous.

## Timing
- **Reset values (one edge with `rst_sig`=1)**
  - PM[0]=0; PM[1..3]=4.
  - All survivors 0; `cnt`=0.
  - `dec_sig`=0; `dec_vld_sig`=0; `err_cnt_sig`=0.
- **Reset priority:** reset mid-stream discards all history. The next accepted symbol is treated as symbol 0.
- **Throughput:** one symbol per clock; no back-pressure.
- **Latency**
  - With continuous `en_sig`, the bit for the symbol accepted at edge e appears on `dec_sig` after edge e+TB_DEPTH-1.
  - In general, the decision for accepted symbol j is output on the edge that accepts symbol j+TB_DEPTH-1.
- **Startup:** the first TB_DEPTH-1 accepted symbols produce no `dec_vld_sig`.
- **Gaps:** any gap pattern in `en_sig` yields the same output bit sequence as continuous input.

## Configuration
- **Macro:** `VITERBI_ERRCNT_EN`.
- **Defined**
  - Port `err_cnt_sig` exists.
  - On each accepted symbol, it adds the normalization amount (the pre-normalization minimum, 0..2).
  - It saturates at 16'hFFFF and resets to 0.
  - For isolated errors this equals the number of channel bit errors.
- **Undefined:** the port and its logic are absent; decode behaviour is identical.

## Test plan
- **Reset:** hold `rst_sig`=1 for 2 cycles, then feed 20 valid symbols → outputs all 0 during reset; `dec_vld_sig`=0 for the first 15 accepted symbols and 1 from the 16th onward.
- **Error-free, `mseries` M=4 source:** drive `ConvEncode` → `viterbi_decode`, continuous `en_sig` → the `dec_sig` stream equals the source bit stream delayed 15 accepted symbols (default TB_DEPTH=16) for 200 symbols; `err_cnt_sig`=0.
- **Isolated errors:** XOR `encode_sig[1]` on symbols 40, 80 and 120 → decoded stream still exact; `err_cnt_sig`=3 by symbol 140.
- **Gapped input:** same source as the error-free case, `en_sig` low on random 30% of cycles → identical decoded sequence; `dec_vld_sig` high only on edges where `en_sig`=1.
- **Mid-stream reset:** pulse `rst_sig` for one cycle at symbol 50 → next edge shows `dec_vld_sig`=0, `err_cnt_sig`=0; refill takes 15 accepted symbols; decoding is then exact relative to post-reset input.
- **All-zero symbols:** feed 100 symbols of 2'b00 → `dec_sig`=0 whenever valid; PM[0] stays 0; no counter change.
